load_store_unit: RTL and testbench

//  Data-memory access stage downstream of the multi-cycle controller.
//  - Consumes memRead/memWrite/isByte/isHalf/isWord and func3 from the controller, the ALU address and rs2 store data.
//  - Performs one byte/half/word access on a req/ack data bus, placing store data on the correct byte lanes.
//  - Returns sign- or zero-extended load data for the memToReg mux, with a done pulse the controller waits on.

---
 rtl/load_store_unit_if.sv | 23 ++
 rtl/load_store_unit.sv | 155 +++++++++++++++
 tb/tb_load_store_unit.sv | 233 +++++++++++++++++++++++
 3 files changed

// File: rtl/load_store_unit_if.sv
// Data-memory bus between the load/store unit (master) and memory (slave).
// One request is held until a single-cycle ack; rdata is valid with ack.
interface load_store_unit_if #(
   parameter int WIDTH = 32
);
   logic             req;
   logic             we;
   logic [WIDTH-1:0] addr;
   logic [3:0]       be;
   logic [WIDTH-1:0] wdata;
   logic [WIDTH-1:0] rdata;
   logic             ack;

   modport master (
      output req, we, addr, be, wdata,
      input  rdata, ack
   );

   modport slave (
      input  req, we, addr, be, wdata,
      output rdata, ack
   );
endinterface

// File: rtl/load_store_unit.sv
// Byte/half/word load-store stage on a req/ack bus with lane steering and load extension.
// Optional MISALIGN_TRAP_EN turns misaligned half/word accesses into an immediate error.
module load_store_unit #(
   parameter int WIDTH    = 32,
   parameter int MAX_WAIT = 255
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              memRead,
   input  logic              memWrite,
   input  logic              isByte,
   input  logic              isHalf,
   input  logic              isWord,
   input  logic [2:0]        func3,
   input  logic [WIDTH-1:0]  addr,
   input  logic [WIDTH-1:0]  wdata,
   output logic [WIDTH-1:0]  rdata,
   output logic              ls_busy,
   output logic              ls_done,
   output logic              ls_err,
   load_store_unit_if.master bus
);

   typedef enum logic [1:0] {IDLE, REQ, DONE, ERR} stateT;
   typedef enum logic [1:0] {SIZE_BYTE, SIZE_HALF, SIZE_WORD} sizeT;

   stateT            state, nextState;
   sizeT             startSize, curSize;
   logic [1:0]       curOffset;
   logic             curUnsigned;
   logic [7:0]       waitCnt;
   logic             start, startErr, misaligned;
   logic [3:0]       startBe;
   logic [WIDTH-1:0] startWdata, loadData;
   logic [7:0]       laneByte;
   logic [15:0]      laneHalf;
   logic             unusedFunc3;

   // Only func3[2] (unsigned load) matters to this stage.
   assign unusedFunc3 = ^func3[1:0];
   assign start       = memRead | memWrite;

`ifdef MISALIGN_TRAP_EN
   assign misaligned = (isWord & (addr[1:0] != 2'b00)) | (~isWord & isHalf & addr[0]);
`else
   assign misaligned = 1'b0;
`endif

   assign startErr = (memRead & memWrite) | ~(isByte | isHalf | isWord) | misaligned;

   // Size decode with word > half > byte priority, plus lane steering of store data.
   always_comb begin
      startSize  = SIZE_BYTE;
      startBe    = 4'b0001 << addr[1:0];
      startWdata = {4{wdata[7:0]}};
      if (isWord) begin
         startSize  = SIZE_WORD;
         startBe    = 4'b1111;
         startWdata = wdata;
      end else if (isHalf) begin
         startSize  = SIZE_HALF;
         startBe    = 4'b0011 << {addr[1], 1'b0};
         startWdata = {2{wdata[15:0]}};
      end
   end

   // Pick the addressed lane out of the returned word and extend it.
   always_comb begin
      case (curOffset)
         2'd0:    laneByte = bus.rdata[7:0];
         2'd1:    laneByte = bus.rdata[15:8];
         2'd2:    laneByte = bus.rdata[23:16];
         default: laneByte = bus.rdata[31:24];
      endcase
      laneHalf = curOffset[1] ? bus.rdata[31:16] : bus.rdata[15:0];
      case (curSize)
         SIZE_BYTE: loadData = curUnsigned ? {{(WIDTH-8){1'b0}}, laneByte}
                                           : {{(WIDTH-8){laneByte[7]}}, laneByte};
         SIZE_HALF: loadData = curUnsigned ? {{(WIDTH-16){1'b0}}, laneHalf}
                                           : {{(WIDTH-16){laneHalf[15]}}, laneHalf};
         default:   loadData = bus.rdata;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else       state <= nextState;
   end

   // Ack takes priority over the timeout when both land in the same cycle.
   always_comb begin
      nextState = state;
      ls_busy   = 1'b1;
      ls_done   = 1'b0;
      ls_err    = 1'b0;
      bus.req   = 1'b0;
      case (state)
         IDLE: begin
            ls_busy = 1'b0;
            if (start) nextState = startErr ? ERR : REQ;
         end
         REQ: begin
            bus.req = 1'b1;
            if (bus.ack)                             nextState = DONE;
            else if (waitCnt == 8'(MAX_WAIT - 1)) nextState = ERR;
         end
         DONE: begin
            ls_done   = 1'b1;
            nextState = IDLE;
         end
         ERR: begin
            ls_done   = 1'b1;
            ls_err    = 1'b1;
            nextState = IDLE;
         end
         default: nextState = IDLE;
      endcase
   end

   // Request attributes are frozen at start so the bus stays stable while waiting.
   always_ff @(posedge clk) begin
      if (reset) begin
         rdata       <= '0;
         bus.we      <= 1'b0;
         bus.addr    <= '0;
         bus.be      <= 4'b0000;
         bus.wdata   <= '0;
         curSize     <= SIZE_BYTE;
         curOffset   <= 2'b00;
         curUnsigned <= 1'b0;
         waitCnt     <= 8'd0;
      end else begin
         if (state == IDLE && start) begin
            bus.we      <= memWrite;
            bus.addr    <= {addr[WIDTH-1:2], 2'b00};
            bus.be      <= startBe;
            bus.wdata   <= startWdata;
            curSize     <= startSize;
            curOffset   <= addr[1:0];
            curUnsigned <= func3[2];
         end
         if (state == REQ) begin
            if (bus.ack) begin
               waitCnt <= 8'd0;
               if (!bus.we) rdata <= loadData;
            end else begin
               waitCnt <= waitCnt + 8'd1;
            end
         end else begin
            waitCnt <= 8'd0;
         end
      end
   end

endmodule

// File: tb/tb_load_store_unit.sv
// Testbench for load_store_unit: transaction-level expectation model checked every cycle,
// plus directed literal checks. Define MISALIGN_TRAP_EN to match a trapping build.
module tb_load_store_unit;

   logic        clk = 1'b0;
   logic        reset;
   logic        memRead, memWrite, isByte, isHalf, isWord;
   logic [2:0]  func3;
   logic [31:0] addr, wdata;
   logic [31:0] rdata;
   logic        ls_busy, ls_done, ls_err;

   load_store_unit_if #(.WIDTH(32)) busIf ();

   load_store_unit #(.WIDTH(32), .MAX_WAIT(255)) dut (
      .clk      (clk),
      .reset    (reset),
      .memRead  (memRead),
      .memWrite (memWrite),
      .isByte   (isByte),
      .isHalf   (isHalf),
      .isWord   (isWord),
      .func3    (func3),
      .addr     (addr),
      .wdata    (wdata),
      .rdata    (rdata),
      .ls_busy  (ls_busy),
      .ls_done  (ls_done),
      .ls_err   (ls_err),
      .bus      (busIf.master)
   );

   always #5 clk = ~clk;

   int          vectors = 0;
   int          miscompares = 0;
   int          doneCount = 0;
   int          reqCycles;
   bit          checkEn = 1'b0;
   logic        expReq = 0, expBusy = 0, expDone = 0, expErr = 0, expWe = 0;
   logic [31:0] expRdata = 0, expAddr = 0, expWdata = 0;
   logic [3:0]  expBe = 0;
   logic        snapWe;
   logic [31:0] snapAddr, snapWdata;
   logic [3:0]  snapBe;

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] required);
      vectors++;
      if (actual !== required) begin
         miscompares++;
         $display("[TB] FAIL %s: actual=%08h required=%08h", name, actual, required);
      end
   endtask

   function automatic logic [31:0] expectedLoad(input int sizeBytes, input logic [31:0] a,
                                                input logic uns, input logic [31:0] d);
      logic [31:0] v;
      if (sizeBytes == 4) return d;
      v = d >> (8 * ((sizeBytes == 2) ? (a & 32'd2) : (a & 32'd3)));
      if (sizeBytes == 2) return uns ? {16'h0, v[15:0]} : {{16{v[15]}}, v[15:0]};
      return uns ? {24'h0, v[7:0]} : {{24{v[7]}}, v[7:0]};
   endfunction

   function automatic logic [3:0] expectedBe(input int sizeBytes, input logic [31:0] a);
      if (sizeBytes == 4) return 4'b1111;
      if (sizeBytes == 2) return 4'b0011 << (a & 32'd2);
      return 4'b0001 << (a & 32'd3);
   endfunction

   function automatic logic [31:0] expectedWdata(input int sizeBytes, input logic [31:0] wd);
      if (sizeBytes == 4) return wd;
      if (sizeBytes == 2) return {16'h0, wd[15:0]} * 32'h0001_0001;
      return {24'h0, wd[7:0]} * 32'h0101_0101;
   endfunction

   always @(negedge clk) begin
      if (checkEn) begin
         if (ls_done) doneCount++;
         checkOutput("ls_busy", {31'b0, ls_busy}, {31'b0, expBusy});
         checkOutput("ls_done", {31'b0, ls_done}, {31'b0, expDone});
         checkOutput("ls_err", {31'b0, ls_err}, {31'b0, expErr});
         checkOutput("bus_req", {31'b0, busIf.req}, {31'b0, expReq});
         checkOutput("rdata", rdata, expRdata);
         if (expReq) begin
            checkOutput("bus_addr", busIf.addr, expAddr);
            checkOutput("bus_we", {31'b0, busIf.we}, {31'b0, expWe});
            checkOutput("bus_be", {28'b0, busIf.be}, {28'b0, expBe});
            if (expWe) checkOutput("bus_wdata", busIf.wdata, expWdata);
         end
      end
   end

   // Runs one access from the cycle after a rising edge; ackDelay<0 means no ack,
   // resetAt>=0 pulses reset during that REQ cycle.
   task automatic applyStimulus(input logic rd, input logic wr, input logic b, input logic h,
                                input logic w, input logic [2:0] f3, input logic [31:0] a,
                                input logic [31:0] wd, input int ackDelay,
                                input logic [31:0] brd, input int resetAt);
      int   sizeBytes;
      logic err;
      sizeBytes = w ? 4 : h ? 2 : b ? 1 : 0;
      err = (rd & wr) | (sizeBytes == 0);
`ifdef MISALIGN_TRAP_EN
      err = err | (sizeBytes == 2 && a[0]) | (sizeBytes == 4 && a[1:0] != 2'b00);
`endif
      reqCycles = 0;
      memRead = rd; memWrite = wr; isByte = b; isHalf = h; isWord = w;
      func3 = f3; addr = a; wdata = wd;
      @(posedge clk); #1;
      memRead = 0; memWrite = 0; isByte = ~b; isHalf = ~h; isWord = ~w;
      func3 = ~f3; addr = ~a; wdata = ~wd;
      if (err) begin
         expBusy = 1; expDone = 1; expErr = 1;
         @(negedge clk);
         if (busIf.req) reqCycles++;
         @(posedge clk); #1;
         expBusy = 0; expDone = 0; expErr = 0;
         return;
      end
      expReq = 1; expBusy = 1; expWe = wr;
      expAddr = {a[31:2], 2'b00};
      expBe = expectedBe(sizeBytes, a);
      expWdata = expectedWdata(sizeBytes, wd);
      for (int k = 0; k < 255; k++) begin
         if (k == ackDelay) begin busIf.ack = 1; busIf.rdata = brd; end
         if (k == 1) memRead = 1;
         @(negedge clk);
         if (busIf.req) reqCycles++;
         if (k == 0) begin
            snapWe = busIf.we; snapAddr = busIf.addr; snapBe = busIf.be; snapWdata = busIf.wdata;
         end
         if (k == resetAt) reset = 1;
         @(posedge clk); #1;
         busIf.ack = 0; memRead = 0; busIf.rdata = $urandom;
         if (k == resetAt) begin
            reset = 0;
            expReq = 0; expBusy = 0; expRdata = 0;
            checkOutput("reset mid bus_req", {31'b0, busIf.req}, 32'd0);
            checkOutput("reset mid ls_busy", {31'b0, ls_busy}, 32'd0);
            checkOutput("reset mid rdata", rdata, 32'd0);
            return;
         end
         if (k == ackDelay) begin
            expReq = 0; expDone = 1;
            if (!wr) expRdata = expectedLoad(sizeBytes, a, f3[2], brd);
            @(posedge clk); #1;
            expDone = 0; expBusy = 0;
            return;
         end
      end
      expReq = 0; expDone = 1; expErr = 1;
      @(posedge clk); #1;
      expDone = 0; expErr = 0; expBusy = 0;
   endtask

   initial begin
      #500000;
      $display("[TB] FAIL watchdog: actual=timeout required=finish");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int d0;
      reset = 1; memRead = 0; memWrite = 0; isByte = 0; isHalf = 0; isWord = 0;
      func3 = 0; addr = 0; wdata = 0; busIf.ack = 0; busIf.rdata = 0;
      repeat (2) @(posedge clk);
      #1;
      checkOutput("reset rdata", rdata, 32'd0);
      checkOutput("reset busy/done/err", {29'b0, ls_busy, ls_done, ls_err}, 32'd0);
      checkOutput("reset bus_req/we", {30'b0, busIf.req, busIf.we}, 32'd0);
      checkOutput("reset bus_addr", busIf.addr, 32'd0);
      checkOutput("reset bus_be", {28'b0, busIf.be}, 32'd0);
      checkOutput("reset bus_wdata", busIf.wdata, 32'd0);
      reset = 0;
      checkEn = 1;

      d0 = doneCount;
      applyStimulus(1, 0, 0, 0, 1, 3'b010, 32'h100, 32'h0, 3, 32'hDEADBEEF, -1);
      checkOutput("t1 rdata", rdata, 32'hDEADBEEF);
      checkOutput("t1 bus_be", {28'b0, snapBe}, 32'hF);
      checkOutput("t1 bus_addr", snapAddr, 32'h100);
      checkOutput("t1 done pulses", doneCount - d0, 32'd1);

      busIf.ack = 1; busIf.rdata = 32'h5555_5555;
      @(posedge clk); #1;
      busIf.ack = 0;

      applyStimulus(1, 0, 1, 0, 0, 3'b000, 32'h103, 32'h0, 0, 32'h8012_3456, -1);
      checkOutput("t2 lb rdata", rdata, 32'hFFFF_FF80);
      applyStimulus(1, 0, 1, 0, 0, 3'b100, 32'h103, 32'h0, 1, 32'h8012_3456, -1);
      checkOutput("t2 lbu rdata", rdata, 32'h0000_0080);
      applyStimulus(1, 0, 0, 1, 0, 3'b101, 32'h102, 32'h0, 2, 32'hBEEF_1234, -1);
      applyStimulus(1, 0, 0, 1, 0, 3'b001, 32'h100, 32'h0, 0, 32'h1234_F00D, -1);
      checkOutput("lh rdata", rdata, 32'hFFFF_F00D);

      applyStimulus(0, 1, 0, 1, 0, 3'b001, 32'h102, 32'h1234_ABCD, 2, 32'hFFFF_FFFF, -1);
      checkOutput("t3 bus_we", {31'b0, snapWe}, 32'd1);
      checkOutput("t3 bus_be", {28'b0, snapBe}, 32'hC);
      checkOutput("t3 bus_wdata", snapWdata, 32'hABCD_ABCD);
      applyStimulus(0, 1, 1, 0, 0, 3'b000, 32'h101, 32'h0000_00AB, 1, 32'h0, -1);
      applyStimulus(0, 1, 0, 0, 1, 3'b010, 32'h104, 32'hCAFE_F00D, 0, 32'h0, -1);

      applyStimulus(1, 0, 1, 0, 1, 3'b000, 32'h108, 32'h0, 1, 32'h8765_4321, -1);
      checkOutput("priority word rdata", rdata, 32'h8765_4321);
      applyStimulus(1, 1, 0, 0, 1, 3'b010, 32'h10C, 32'h0, -1, 32'h0, -1);
      applyStimulus(1, 0, 0, 0, 0, 3'b010, 32'h10C, 32'h0, -1, 32'h0, -1);
      checkOutput("no-size err req cycles", reqCycles, 32'd0);

      d0 = doneCount;
      applyStimulus(1, 0, 0, 0, 1, 3'b010, 32'h110, 32'h0, -1, 32'h0, -1);
      checkOutput("t4 req cycles", reqCycles, 32'd255);
      checkOutput("t4 rdata held", rdata, 32'h8765_4321);
      checkOutput("t4 done pulses", doneCount - d0, 32'd1);

      applyStimulus(1, 0, 0, 1, 0, 3'b001, 32'h101, 32'h0, 0, 32'h0000_8001, -1);
`ifdef MISALIGN_TRAP_EN
      checkOutput("t5 trap req cycles", reqCycles, 32'd0);
      checkOutput("t5 trap rdata held", rdata, 32'h8765_4321);
`else
      checkOutput("t5 bus_be", {28'b0, snapBe}, 32'h3);
      checkOutput("t5 rdata", rdata, 32'hFFFF_8001);
`endif

      applyStimulus(1, 0, 0, 0, 1, 3'b010, 32'h200, 32'h0, -1, 32'h0, 3);
      applyStimulus(1, 0, 0, 0, 1, 3'b010, 32'h200, 32'h0, 0, 32'h1234_5678, -1);
      checkOutput("t6 rdata after reset", rdata, 32'h1234_5678);

      repeat (2) @(posedge clk);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
